// File: rtl/simd_fetch.sv
// Instruction fetch stage feeding the SIMD decoder: walks instruction memory from
// start_pc, hands each word off over valid/ready, and stops after a RETURN word.
module simd_fetch #(
    parameter int PC_WIDTH  = 9,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  start_pc,
    input  logic                 abort,
    output logic                 imem_req_valid,
    output logic [PC_WIDTH-1:0]  imem_req_addr,
    input  logic                 imem_req_ready,
    input  logic                 imem_resp_valid,
    input  logic [31:0]          imem_resp_data,
    output logic                 instr_valid,
    output logic [31:0]          instruction,
    input  logic                 instr_ready,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [PC_WIDTH-1:0]    pc_r;
    logic [31:0]            instr_r;
    logic [CNT_WIDTH-1:0]   cnt_r;

    function automatic logic is_return(input logic [31:0] word);
        return (word[31:21] == 11'h7FF);
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort outranks every other transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt_s = S_REQ;
                else       state_nxt_s = S_IDLE;
            end
            S_REQ: begin
                if (abort)               state_nxt_s = S_IDLE;
                else if (imem_req_ready) state_nxt_s = S_WAIT;
                else                     state_nxt_s = S_REQ;
            end
            S_WAIT: begin
                // A response landing in the abort cycle is dropped and nothing is left outstanding.
                if (abort) begin
                    if (imem_resp_valid) state_nxt_s = S_IDLE;
                    else                 state_nxt_s = S_DRAIN;
                end else if (imem_resp_valid) begin
                    state_nxt_s = S_HOLD;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (abort)                 state_nxt_s = S_IDLE;
                else if (!instr_ready)     state_nxt_s = S_HOLD;
                else if (is_return(instr_r)) state_nxt_s = S_DONE;
                else                       state_nxt_s = S_REQ;
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            S_DRAIN: begin
                if (imem_resp_valid) state_nxt_s = S_IDLE;
                else                 state_nxt_s = S_DRAIN;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded purely from the state register.
    always_comb begin
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        done           = 1'b0;
        busy           = 1'b1;
        case (state_r)
            S_IDLE:  busy           = 1'b0;
            S_REQ:   imem_req_valid = 1'b1;
            S_HOLD:  instr_valid    = 1'b1;
            S_DONE:  done           = 1'b1;
            default: busy           = 1'b1;
        endcase
    end

    // Datapath: program counter, captured word and saturating handoff counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= '0;
            instr_r <= 32'h0000_0000;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        pc_r  <= start_pc;
                        cnt_r <= '0;
                    end
                end
                S_WAIT: begin
                    if (!abort && imem_resp_valid) begin
                        instr_r <= imem_resp_data;
                        pc_r    <= pc_r + PC_WIDTH'(1);
                    end
                end
                S_HOLD: begin
                    if (!abort && instr_ready && (cnt_r != {CNT_WIDTH{1'b1}})) begin
                        cnt_r <= cnt_r + CNT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_req_addr = pc_r;
    assign pc            = pc_r;
    assign instruction   = instr_r;
    assign instr_count   = cnt_r;

endmodule

// File: tb/tb_simd_fetch.sv
// Directed bench for simd_fetch: behavioural instruction memory plus a queue of
// expected handoff words, checked with immediate assertions.
module tb_simd_fetch;
    localparam int PW = 9;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, imem_req_ready, instr_ready;
    logic [PW-1:0] start_pc;
    logic          imem_resp_valid = 1'b0;
    logic [31:0]   imem_resp_data  = 32'h0;
    logic          imem_req_valid, instr_valid, busy, done;
    logic [PW-1:0] imem_req_addr, pc;
    logic [31:0]   instruction;
    logic [CW-1:0] instr_count;

    logic [31:0]   mem [0:511];
    int            resp_delay = 0;
    logic          stray = 1'b0;
    logic [31:0]   exp_q[$];
    logic [PW-1:0] req_log[$];
    int            n_checks = 0, n_fail = 0, n_hand = 0, n_acc = 0;

    simd_fetch #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .abort(abort),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .instr_valid(instr_valid),
        .instruction(instruction), .instr_ready(instr_ready), .pc(pc), .busy(busy),
        .done(done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Memory model: one response per accepted request, resp_delay extra cycles late.
    logic          mem_acc, pend = 1'b0;
    logic [PW-1:0] mem_addr, pend_addr;
    int            pend_wait;
    always @(posedge clk) begin
        mem_acc  = rst_n && imem_req_valid && imem_req_ready;
        mem_addr = imem_req_addr;
        #1;
        imem_resp_valid = 1'b0;
        if (!rst_n) pend = 1'b0;
        if (mem_acc) begin
            pend = 1'b1;
            pend_wait = resp_delay;
            pend_addr = mem_addr;
        end
        if (pend) begin
            if (pend_wait == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem[pend_addr];
                pend = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        if (stray) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'hFFE0_0000;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle, logging request acceptances and scoring handoffs first.
    task automatic tick();
        logic [31:0] e;
        if (rst_n && imem_req_valid && imem_req_ready) begin
            n_acc++;
            req_log.push_back(imem_req_addr);
        end
        if (rst_n && instr_valid && instr_ready && !abort) begin
            n_hand++;
            chk("handoff_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("handoff_word", instruction, e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input logic [PW-1:0] a);
        start_pc = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run(input int budget, output int dc, output int da);
        dc = 0;
        da = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (done === 1'b1) begin
                dc++;
                if (da < 0) da = i;
            end
            if (busy === 1'b0) break;
        end
        chk("run_reaches_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int dc, da, h0, a0, w;
        rst_n = 1'b0; start = 1'b0; start_pc = '0; abort = 1'b0;
        imem_req_ready = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0000_0000;
        repeat (2) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic two-word program ending in RETURN.
        mem[9'h010] = 32'h8B02_0020;
        mem[9'h011] = 32'hFFE0_0000;
        exp_q.push_back(32'h8B02_0020);
        exp_q.push_back(32'hFFE0_0000);
        h0 = n_hand;
        req_log.delete();
        do_start(9'h010);
        run(20, dc, da);
        chk("t1_done_pulses", 32'(dc), 32'd1);
        chk("t1_done_cycle", 32'(da), 32'd6);
        chk("t1_handoffs", 32'(n_hand - h0), 32'd2);
        chk("t1_count", 32'(instr_count), 32'd2);
        chk("t1_pc", 32'(pc), 32'h012);
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t1_req_count", 32'(req_log.size()), 32'd2);

        // Decoder backpressure on the first word.
        instr_ready = 1'b0;
        mem[9'h020] = 32'h1234_5678;
        mem[9'h021] = 32'hFFE0_0001;
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'hFFE0_0001);
        do_start(9'h020);
        for (int i = 0; i < 10 && !instr_valid; i++) tick();
        chk("t2_valid_seen", 32'(instr_valid), 32'd1);
        repeat (5) begin
            chk("t2_hold_valid", 32'(instr_valid), 32'd1);
            chk("t2_hold_word", instruction, 32'h1234_5678);
            chk("t2_no_req", 32'(imem_req_valid), 32'd0);
            chk("t2_count_held", 32'(instr_count), 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        run(20, dc, da);
        chk("t2_done_pulses", 32'(dc), 32'd1);
        chk("t2_count", 32'(instr_count), 32'd2);

        // Memory stall on both request and response.
        imem_req_ready = 1'b0;
        resp_delay = 3;
        mem[9'h030] = 32'hFFE0_1234;
        exp_q.push_back(32'hFFE0_1234);
        a0 = n_acc;
        do_start(9'h030);
        repeat (4) begin
            chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
            chk("t3_req_addr", 32'(imem_req_addr), 32'h030);
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        w = 0;
        while (!instr_valid && w < 10) begin
            tick();
            w++;
        end
        chk("t3_resp_latency", 32'(w), 32'd4);
        chk("t3_word", instruction, 32'hFFE0_1234);
        run(20, dc, da);
        chk("t3_one_request", 32'(n_acc - a0), 32'd1);
        chk("t3_count", 32'(instr_count), 32'd1);
        resp_delay = 0;

        // Abort while a response is outstanding.
        resp_delay = 1;
        mem[9'h040] = 32'h0000_0040;
        do_start(9'h040);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_drain_busy", 32'(busy), 32'd1);
        chk("t4_drain_no_valid", 32'(instr_valid), 32'd0);
        chk("t4_drain_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_no_valid", 32'(instr_valid), 32'd0);
        resp_delay = 0;
        mem[9'h050] = 32'hFFE0_0050;
        exp_q.push_back(32'hFFE0_0050);
        do_start(9'h050);
        run(20, dc, da);
        chk("t4_restart_done", 32'(dc), 32'd1);
        chk("t4_restart_count", 32'(instr_count), 32'd1);
        chk("t4_restart_pc", 32'(pc), 32'h051);

        // Program counter wraps past the top of memory.
        mem[9'h1FF] = 32'h0000_0013;
        mem[9'h000] = 32'hFFFF_FFFF;
        exp_q.push_back(32'h0000_0013);
        exp_q.push_back(32'hFFFF_FFFF);
        req_log.delete();
        do_start(9'h1FF);
        run(20, dc, da);
        chk("t5_req_count", 32'(req_log.size()), 32'd2);
        if (req_log.size() == 2) chk("t5_wrap_addr", 32'(req_log[1]), 32'h000);
        chk("t5_pc", 32'(pc), 32'h001);
        chk("t5_count", 32'(instr_count), 32'd2);

        // Asynchronous reset while holding a word.
        mem[9'h060] = 32'h0000_AAAA;
        mem[9'h061] = 32'hFFE0_0061;
        exp_q.push_back(32'h0000_AAAA);
        exp_q.push_back(32'hFFE0_0061);
        do_start(9'h060);
        for (int i = 0; i < 10 && instr_count != 16'd1; i++) tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 10 && !instr_valid; i++) tick();
        chk("t6_held_word", instruction, 32'hFFE0_0061);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(instr_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_count", 32'(instr_count), 32'd0);
        chk("t6_rst_pc", 32'(pc), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        repeat (3) begin
            chk("t6_stray_valid", 32'(instr_valid), 32'd0);
            chk("t6_stray_busy", 32'(busy), 32'd0);
            chk("t6_stray_count", 32'(instr_count), 32'd0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
